// File: rtl/hazard_info_pipe_pkg.sv
// hazard_info_pipe_pkg: shared bubble field values and Tnew width constants
package hazard_info_pipe_pkg;
  localparam int TNEW_W = 4;
  localparam int SAT_DEC_W = TNEW_W;
  localparam logic [4:0] BUBBLE_REG = 5'd0;
  localparam logic BUBBLE_RW = 1'b0;
  localparam int BUBBLE_TNEW = 0;
  localparam logic BUBBLE_VALID = 1'b0;
endpackage

// File: rtl/hazard_info_pipe_if.sv
// hazard_info_pipe_if: D-stage inputs and E/M/W hazard-info outputs
interface hazard_info_pipe_if #(
  parameter int CNT_W = 16,
  parameter int TNEW_W = 4
);
  logic stall;
  logic flush_E;
  logic [4:0] rs_D, rt_D, RegAddr_D;
  logic RegWrite_D;
  logic [TNEW_W-1:0] Tnew_D;
  logic [4:0] rs_E, rt_E, RegAddr_E;
  logic RegWrite_E;
  logic [TNEW_W-1:0] Tnew_E;
  logic [4:0] rt_M, RegAddr_M;
  logic RegWrite_M;
  logic [TNEW_W-1:0] Tnew_M;
  logic [4:0] RegAddr_W;
  logic RegWrite_W;
  logic [TNEW_W-1:0] Tnew_W;
  logic bubble_E, bubble_M, bubble_W;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output stall, flush_E, rs_D, rt_D, RegAddr_D, RegWrite_D, Tnew_D,
    input rs_E, rt_E, RegAddr_E, RegWrite_E, Tnew_E, rt_M, RegAddr_M, RegWrite_M, Tnew_M,
    input RegAddr_W, RegWrite_W, Tnew_W, bubble_E, bubble_M, bubble_W, stall_cnt
  );
  modport slave (
    input stall, flush_E, rs_D, rt_D, RegAddr_D, RegWrite_D, Tnew_D,
    output rs_E, rt_E, RegAddr_E, RegWrite_E, Tnew_E, rt_M, RegAddr_M, RegWrite_M, Tnew_M,
    output RegAddr_W, RegWrite_W, Tnew_W, bubble_E, bubble_M, bubble_W, stall_cnt
  );
endinterface

// File: rtl/hazard_info_pipe_stage_reg.sv
// hazard_stage_reg: one pipeline stage of hazard info with bubble insert and optional Tnew decrement
module hazard_stage_reg #(
  parameter int TNEW_W = 4,
  parameter bit DEC = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill_i,
  input  logic              valid_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        addr_i,
  input  logic              rw_i,
  input  logic [TNEW_W-1:0] tnew_i,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        addr_o,
  output logic              rw_o,
  output logic [TNEW_W-1:0] tnew_o,
  output logic              bubble_o
);
  import hazard_info_pipe_pkg::*;
  logic [4:0] rs_q, rs_d, rt_q, rt_d, addr_q, addr_d;
  logic rw_q, rw_d, valid_q, valid_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d, tnew_dec;
  // select bubble or upstream fields; downstream stages saturate Tnew toward zero
  always_comb begin
    tnew_dec = (DEC && tnew_i != '0) ? tnew_i - 1'b1 : tnew_i;
    rs_d = kill_i ? BUBBLE_REG : rs_i;
    rt_d = kill_i ? BUBBLE_REG : rt_i;
    addr_d = kill_i ? BUBBLE_REG : addr_i;
    rw_d = kill_i ? BUBBLE_RW : rw_i;
    tnew_d = kill_i ? TNEW_W'(BUBBLE_TNEW) : tnew_dec;
    valid_d = kill_i ? BUBBLE_VALID : valid_i;
  end
  // stage register; reset clears everything, so the stage reads as a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q <= '0;
      rt_q <= '0;
      addr_q <= '0;
      rw_q <= 1'b0;
      tnew_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rs_q <= rs_d;
      rt_q <= rt_d;
      addr_q <= addr_d;
      rw_q <= rw_d;
      tnew_q <= tnew_d;
      valid_q <= valid_d;
    end
  end
  assign rs_o = rs_q;
  assign rt_o = rt_q;
  assign addr_o = addr_q;
  assign rw_o = rw_q;
  assign tnew_o = tnew_q;
  assign bubble_o = ~valid_q;
endmodule

// File: rtl/hazard_info_pipe.sv
// hazard_info_pipe: E/M/W hazard-info pipeline with stall/flush bubbles and saturating stall counter
module hazard_info_pipe #(
  parameter int CNT_W = 16,
  parameter int TNEW_W = hazard_info_pipe_pkg::TNEW_W
) (
  input logic clk,
  input logic reset,
  hazard_info_pipe_if.slave bus
);
  logic kill_e, rw_norm;
  logic [4:0] unused_rs_m, unused_rs_w, unused_rt_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign kill_e = bus.stall | bus.flush_E;
  assign rw_norm = bus.RegWrite_D & (bus.RegAddr_D != 5'd0);
  hazard_stage_reg #(.TNEW_W(TNEW_W), .DEC(1'b0)) u_e (
    .clk(clk), .rst_n(reset), .kill_i(kill_e), .valid_i(1'b1),
    .rs_i(bus.rs_D), .rt_i(bus.rt_D), .addr_i(bus.RegAddr_D), .rw_i(rw_norm), .tnew_i(bus.Tnew_D),
    .rs_o(bus.rs_E), .rt_o(bus.rt_E), .addr_o(bus.RegAddr_E), .rw_o(bus.RegWrite_E),
    .tnew_o(bus.Tnew_E), .bubble_o(bus.bubble_E)
  );
  hazard_stage_reg #(.TNEW_W(TNEW_W), .DEC(1'b1)) u_m (
    .clk(clk), .rst_n(reset), .kill_i(1'b0), .valid_i(~bus.bubble_E),
    .rs_i(bus.rs_E), .rt_i(bus.rt_E), .addr_i(bus.RegAddr_E), .rw_i(bus.RegWrite_E), .tnew_i(bus.Tnew_E),
    .rs_o(unused_rs_m), .rt_o(bus.rt_M), .addr_o(bus.RegAddr_M), .rw_o(bus.RegWrite_M),
    .tnew_o(bus.Tnew_M), .bubble_o(bus.bubble_M)
  );
  hazard_stage_reg #(.TNEW_W(TNEW_W), .DEC(1'b1)) u_w (
    .clk(clk), .rst_n(reset), .kill_i(1'b0), .valid_i(~bus.bubble_M),
    .rs_i(unused_rs_m), .rt_i(bus.rt_M), .addr_i(bus.RegAddr_M), .rw_i(bus.RegWrite_M), .tnew_i(bus.Tnew_M),
    .rs_o(unused_rs_w), .rt_o(unused_rt_w), .addr_o(bus.RegAddr_W), .rw_o(bus.RegWrite_W),
    .tnew_o(bus.Tnew_W), .bubble_o(bus.bubble_W)
  );
  // count stalled cycles, holding at all-ones
  always_comb cnt_d = (bus.stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // stall counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_info_pipe.sv
// tb_hazard_info_pipe: directed vector table plus reset and counter-saturation sequences
module tb_hazard_info_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  hazard_info_pipe_if #(.CNT_W(16), .TNEW_W(4)) bus ();
  hazard_info_pipe #(.CNT_W(16), .TNEW_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic st, fl;
    logic [4:0] rs, rt, a;
    logic rw;
    logic [3:0] t;
    logic [4:0] ea;
    logic erw;
    logic [3:0] et;
    logic eb;
    logic [4:0] mrt, ma;
    logic mrw;
    logic [3:0] mt;
    logic mb;
    logic [4:0] wa;
    logic wrw;
    logic [3:0] wt;
    logic wb;
    logic [15:0] cnt;
  } vec_t;
  vec_t v[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] a, input logic rw, input logic [3:0] t);
    bus.stall = st;
    bus.flush_E = fl;
    bus.rs_D = rs;
    bus.rt_D = rt;
    bus.RegAddr_D = a;
    bus.RegWrite_D = rw;
    bus.Tnew_D = t;
  endtask

  initial begin
    v[0]  = '{0,0, 1, 2, 3,1,2,  3,1,2,0,  0, 0,0,0,1,  0,0,0,1, 0};
    v[1]  = '{0,0, 4, 5, 6,1,0,  6,1,0,0,  2, 3,1,1,0,  0,0,0,1, 0};
    v[2]  = '{1,0, 7, 9, 8,1,3,  0,0,0,1,  5, 6,1,0,0,  3,1,0,0, 1};
    v[3]  = '{1,0, 7, 9, 8,1,3,  0,0,0,1,  0, 0,0,0,1,  6,1,0,0, 2};
    v[4]  = '{0,0, 7, 9, 8,1,3,  8,1,3,0,  0, 0,0,0,1,  0,0,0,1, 2};
    v[5]  = '{0,0, 3, 3, 0,1,1,  0,0,1,0,  9, 8,1,2,0,  0,0,0,1, 2};
    v[6]  = '{1,1, 6, 6,10,1,1,  0,0,0,1,  3, 0,0,0,0,  8,1,1,0, 3};
    v[7]  = '{0,1, 7, 7,11,1,5,  0,0,0,1,  0, 0,0,0,1,  0,0,0,0, 3};
    v[8]  = '{0,0,10,11,12,0,4, 12,0,4,0,  0, 0,0,0,1,  0,0,0,1, 3};
    v[9]  = '{0,0,12,13,13,1,1, 13,1,1,0, 11,12,0,3,0,  0,0,0,1, 3};
    v[10] = '{0,0,14,15,14,1,0, 14,1,0,0, 13,13,1,0,0, 12,0,2,0, 3};
    v[11] = '{0,0,16,17,15,1,0, 15,1,0,0, 15,14,1,0,0, 13,1,0,0, 3};
    drive(1'b1, 1'b0, 5'd31, 5'd30, 5'd29, 1'b1, 4'd7);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fields", 64'({bus.rs_E, bus.rt_E, bus.RegAddr_E, bus.RegWrite_E, bus.Tnew_E, bus.rt_M,
        bus.RegAddr_M, bus.RegWrite_M, bus.Tnew_M, bus.RegAddr_W, bus.RegWrite_W, bus.Tnew_W, bus.stall_cnt}), 64'd0);
    chk("reset_bubbles", 64'({bus.bubble_E, bus.bubble_M, bus.bubble_W}), 64'd7);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(v[i].st, v[i].fl, v[i].rs, v[i].rt, v[i].a, v[i].rw, v[i].t);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_E", i), 64'({bus.rs_E, bus.rt_E, bus.RegAddr_E, bus.RegWrite_E, bus.Tnew_E, bus.bubble_E}),
          64'({v[i].eb ? 5'd0 : v[i].rs, v[i].eb ? 5'd0 : v[i].rt, v[i].ea, v[i].erw, v[i].et, v[i].eb}));
      chk($sformatf("v%0d_M", i), 64'({bus.rt_M, bus.RegAddr_M, bus.RegWrite_M, bus.Tnew_M, bus.bubble_M}),
          64'({v[i].mrt, v[i].ma, v[i].mrw, v[i].mt, v[i].mb}));
      chk($sformatf("v%0d_W", i), 64'({bus.RegAddr_W, bus.RegWrite_W, bus.Tnew_W, bus.bubble_W}),
          64'({v[i].wa, v[i].wrw, v[i].wt, v[i].wb}));
      chk($sformatf("v%0d_cnt", i), 64'(bus.stall_cnt), 64'(v[i].cnt));
    end
    drive(1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 1'b1, 4'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midreset_fields", 64'({bus.rs_E, bus.rt_E, bus.RegAddr_E, bus.RegWrite_E, bus.Tnew_E, bus.rt_M,
        bus.RegAddr_M, bus.RegWrite_M, bus.Tnew_M, bus.RegAddr_W, bus.RegWrite_W, bus.Tnew_W, bus.stall_cnt}), 64'd0);
    chk("midreset_bubbles", 64'({bus.bubble_E, bus.bubble_M, bus.bubble_W}), 64'd7);
    #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd20, 5'd21, 5'd20, 1'b1, 4'd2);
    @(posedge clk);
    #1;
    chk("postreset_E", 64'({bus.rs_E, bus.rt_E, bus.RegAddr_E, bus.RegWrite_E, bus.Tnew_E, bus.bubble_E}),
        64'({5'd20, 5'd21, 5'd20, 1'b1, 4'd2, 1'b0}));
    chk("postreset_MW", 64'({bus.RegAddr_M, bus.bubble_M, bus.bubble_W, bus.stall_cnt}), 64'({5'd0, 1'b1, 1'b1, 16'd0}));
    bus.stall = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_near_max", 64'(bus.stall_cnt), 64'h0000_FFFE);
    repeat (6) @(posedge clk);
    #1;
    chk("cnt_saturated", 64'(bus.stall_cnt), 64'h0000_FFFF);
    chk("sat_bubble_E", 64'({bus.bubble_E, bus.RegWrite_E}), 64'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_info_pipe.md
HAZARD_INFO_PIPE -- requirements
Module: hazard_info_pipe

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 Parameter TNEW_W, default 4, width of every Tnew field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard-unit stall request for the D stage.
REQ-006 flush_E  input  1  synchronous request to kill the instruction entering E.
REQ-007 rs_D, rt_D, RegAddr_D  input  5 each  D-stage source and destination register numbers.
REQ-008 RegWrite_D  input  1  D-stage write enable.
REQ-009 Tnew_D  input  TNEW_W  cycles until the result exists, measured at E entry.
REQ-010 rs_E, rt_E, RegAddr_E  output  5 each  E-stage register fields.
REQ-011 RegWrite_E  output  1  E-stage write enable.
REQ-012 Tnew_E  output  TNEW_W  E-stage Tnew.
REQ-013 rt_M, RegAddr_M  output  5 each  M-stage register fields.
REQ-014 RegWrite_M  output  1  M-stage write enable.
REQ-015 Tnew_M  output  TNEW_W  M-stage Tnew.
REQ-016 RegAddr_W  output  5  W-stage destination register.
REQ-017 RegWrite_W  output  1  W-stage write enable.
REQ-018 Tnew_W  output  TNEW_W  W-stage Tnew.
REQ-019 bubble_E, bubble_M, bubble_W  output  1 each  stage holds an inserted bubble.
REQ-020 stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-021 Every rising clk edge SHALL advance M->W and E->M unconditionally; the downstream stages never stall.
REQ-022 When stall=1 or flush_E=1, E SHALL load a bubble: all fields 0, RegWrite_E=0, Tnew_E=0, bubble_E=1.
REQ-023 Otherwise E SHALL load the D fields and clear bubble_E.
REQ-024 Register-zero normalisation: RegWrite SHALL be stored as RegWrite_D & (RegAddr_D!=0).
REQ-025 Tnew_M SHALL load sat_dec(Tnew_E) and Tnew_W SHALL load sat_dec(Tnew_M), where sat_dec(0)=0 and sat_dec(n)=n-1.
REQ-026 Tnew_E SHALL load Tnew_D unchanged.
REQ-027 rt_M SHALL load rt_E.
REQ-028 The bubble flags SHALL propagate with their stage: bubble_M<=bubble_E and bubble_W<=bubble_M.
REQ-029 stall and flush_E together SHALL produce exactly one bubble.
REQ-030 stall_cnt SHALL increment by 1 on each edge sampled with stall=1.
REQ-031 stall_cnt SHALL hold at all-ones and never wrap.
REQ-032 All outputs SHALL be driven directly from registers, with no combinational input-to-output path.
REQ-033 An asserted stall SHALL be reflected in bubble_E after 1 cycle of latency.

Reset
REQ-034 While reset=0, every register SHALL clear to 0 asynchronously.
REQ-035 During reset, bubble_E, bubble_M and bubble_W SHALL read 1 and stall_cnt SHALL read 0.
REQ-036 On reset deassertion mid-stream, the first edge SHALL load E from D normally; previously in-flight contents are lost.

Structure
REQ-037 The shared header SHALL hold the bubble field values, TNEW_W and the sat_dec width constant.
REQ-038 One sub-module, hazard_stage_reg, SHALL implement a single stage's field register with load/bubble select and Tnew decrement.
REQ-039 hazard_stage_reg SHALL be instantiated three times (E, M, W).
REQ-040 The stall counter SHALL live in the top level.

Verification
REQ-041 Straight-line flow: D={rs=1, rt=2, Addr=3, RW=1, Tnew=2} with stall=0 -> next edge E shows Tnew=2; next edge M shows Addr=3, Tnew=1; next edge W shows Tnew=0.
REQ-042 Stall: stall=1 for 2 cycles while D holds Addr=8 -> E is a bubble for 2 cycles with RegWrite_E=0, then Addr=8 enters E; the previous E instruction still reaches M, then W; stall_cnt=2.
REQ-043 $0 write: RegAddr_D=0, RegWrite_D=1 -> RegWrite_E=0 and stays 0 through W.
REQ-044 Saturation: Tnew_D=0 -> Tnew_E/M/W = 0/0/0; preload stall_cnt near max and hold stall=1 -> stall_cnt stays 0xFFFF.
REQ-045 Mid-stream reset pulse -> all outputs 0 and bubbles 1 immediately, without waiting for a clk edge; the first post-reset edge loads D.
REQ-046 Simultaneous stall=1 and flush_E=1 -> a single bubble in E and stall_cnt +1.
